// File: rtl/alu_mp_ctrl_pkg.sv
// Shared encodings for the multi-precision ALU sequencer: FSM states and opcode fields.
package alu_mp_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Op[2] set selects a logic operation; logic ops break the carry chain.
  localparam int         OP_LOGIC_BIT = 2;
  localparam logic [2:0] OP_ADD       = 3'b000;
  localparam logic [2:0] OP_SUB       = 3'b001;
  localparam logic [2:0] OP_INC       = 3'b010;
  localparam logic [2:0] OP_DEC       = 3'b011;
  localparam logic [2:0] OP_AND       = 3'b100;
  localparam logic [2:0] OP_OR        = 3'b101;
  localparam logic [2:0] OP_XOR       = 3'b110;
  localparam logic [2:0] OP_NOR       = 3'b111;

endpackage

// File: rtl/alu_mp_ctrl_alu.sv
// The existing 4-bit ALU: purely combinational, one nibble with carry-in.
module alu
  import alu_mp_ctrl_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in,
  input  logic [2:0] Op,
  output logic [3:0] R,
  output logic       carry,
  output logic       zero,
  output logic       sign
);

  logic [4:0] sum;

  always_comb begin
    sum   = '0;
    R     = '0;
    carry = 1'b0;
    case (Op)
      OP_ADD: sum = {1'b0, A} + {1'b0, B} + {4'b0, c_in};
      OP_SUB: sum = {1'b0, A} + {1'b0, ~B} + {4'b0, c_in};
      OP_INC: sum = {1'b0, A} + {4'b0, c_in};
      OP_DEC: sum = {1'b0, A} + 5'h0f + {4'b0, c_in};
      default: sum = '0;
    endcase
    case (Op)
      OP_AND:  R = A & B;
      OP_OR:   R = A | B;
      OP_XOR:  R = A ^ B;
      OP_NOR:  R = ~(A | B);
      default: begin
        R     = sum[3:0];
        carry = sum[4];
      end
    endcase
    zero = (R == 4'h0);
    sign = R[3];
  end

endmodule

// File: rtl/alu_mp_ctrl.sv
// Runs a W-bit operation through one 4-bit alu, LS nibble first, chaining carry and zero.
module alu_mp_ctrl
  import alu_mp_ctrl_pkg::*;
#(
  parameter int NIBBLES = 2,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   Op,
  input  logic         c_in,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] R,
  output logic         zero,
  output logic         carry,
  output logic         sign,
  output state_t       state
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  // Handshake: start is taken only while idle; done pulses for one cycle with
  // R and flags already valid, and busy covers acceptance+1 through done.
  logic [W-1:0]  a_q, b_q, work, work_next;
  logic [2:0]    op_q;
  logic [IW-1:0] idx;
  logic          cc, za, cc_next;
  logic [3:0]    a_nib, b_nib, alu_r;
  logic          alu_carry, alu_zero, alu_sign;

  always_comb begin
    a_nib     = '0;
    b_nib     = '0;
    work_next = work;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib            = a_q[4*i +: 4];
        b_nib            = b_q[4*i +: 4];
        work_next[4*i +: 4] = alu_r;
      end
    end
    cc_next = op_q[OP_LOGIC_BIT] ? 1'b0 : alu_carry;
  end

  alu u_alu (
    .A     (a_nib),
    .B     (b_nib),
    .c_in  (cc),
    .Op    (op_q),
    .R     (alu_r),
    .carry (alu_carry),
    .zero  (alu_zero),
    .sign  (alu_sign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      idx   <= '0;
      cc    <= 1'b0;
      za    <= 1'b0;
      work  <= '0;
      R     <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
      sign  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= Op;
            idx   <= '0;
            cc    <= c_in;
            za    <= 1'b1;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          work <= work_next;
          cc   <= cc_next;
          za   <= za & alu_zero;
          idx  <= idx + 1'b1;
          // Results are published on the edge into DONE so they are valid with done.
          if (idx == LAST) begin
            R     <= work_next;
            zero  <= za & alu_zero;
            carry <= cc_next;
            sign  <= alu_sign;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mp_ctrl.sv
// Self-checking bench for alu_mp_ctrl at NIBBLES=2 and NIBBLES=1 against a word-level model.
module tb_alu_mp_ctrl;
  import alu_mp_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start2;
  logic [2:0] op_s;
  logic       c_in_s;
  logic [7:0] a_s, b_s;

  logic       busy2, done2, zero2, carry2, sign2;
  logic [7:0] r2;
  state_t     state2;
  logic       busy1, done1, zero1, carry1, sign1;
  logic [3:0] r1;
  state_t     state1;

  int errors = 0;
  int checks = 0;
  int dc2 = 0;
  int dc1 = 0;
  logic [7:0] prev_r [3];

  always #5 clk = ~clk;

  alu_mp_ctrl #(.NIBBLES(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .Op(op_s), .c_in(c_in_s),
    .A(a_s), .B(b_s), .busy(busy2), .done(done2), .R(r2),
    .zero(zero2), .carry(carry2), .sign(sign2), .state(state2)
  );

  alu_mp_ctrl #(.NIBBLES(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .Op(op_s), .c_in(c_in_s),
    .A(a_s[3:0]), .B(b_s[3:0]), .busy(busy1), .done(done1), .R(r1),
    .zero(zero1), .carry(carry1), .sign(sign1), .state(state1)
  );

  always @(posedge clk) begin
    if (done2 === 1'b1) dc2++;
    if (done1 === 1'b1) dc1++;
  end

  function automatic void sample(input int n, output logic [7:0] r, output logic bz,
                                 output logic dn, output logic z, output logic c,
                                 output logic s);
    if (n == 2) begin
      r = r2; bz = busy2; dn = done2; z = zero2; c = carry2; s = sign2;
    end else begin
      r = {4'h0, r1}; bz = busy1; dn = done1; z = zero1; c = carry1; s = sign1;
    end
  endfunction

  // Whole-word reference: ripple carry across nibbles equals plain W-bit arithmetic.
  function automatic void model(input int n, input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic cin, output logic [7:0] r,
                                output logic z, output logic c, output logic s);
    int w, mask, av, bv, res;
    w    = 4 * n;
    mask = (1 << w) - 1;
    av   = int'(a) & mask;
    bv   = int'(b) & mask;
    case (op)
      3'd0: res = av + bv + int'(cin);
      3'd1: res = av + (~bv & mask) + int'(cin);
      3'd2: res = av + int'(cin);
      3'd3: res = av + mask + int'(cin);
      3'd4: res = av & bv;
      3'd5: res = av | bv;
      3'd6: res = av ^ bv;
      default: res = ~(av | bv) & mask;
    endcase
    r = 8'(res & mask);
    c = op[2] ? 1'b0 : res[w];
    z = ((res & mask) == 0);
    s = res[w-1];
  endfunction

  task automatic run_op(input int n, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input logic [7:0] er,
                        input logic ez, input logic ec, input logic es);
    int lat;
    logic seen;
    logic [7:0] r;
    logic bz, dn, z, c, s;
    @(negedge clk);
    sample(n, r, bz, dn, z, c, s);
    checks++;
    if (bz !== 1'b0 || dn !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_start n=%0d busy=%b done=%b required 0 0", n, bz, dn);
    end
    op_s = op; a_s = a; b_s = b; c_in_s = cin;
    if (n == 2) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    a_s = 8'($urandom); b_s = 8'($urandom); op_s = 3'($urandom); c_in_s = 1'($urandom);
    sample(n, r, bz, dn, z, c, s);
    checks++;
    if (r !== prev_r[n]) begin
      errors++;
      $display("FAIL r_hold n=%0d got=%h required=%h", n, r, prev_r[n]);
    end
    lat = 1;
    seen = 1'b0;
    while (!seen && lat <= 12) begin
      sample(n, r, bz, dn, z, c, s);
      checks++;
      if (bz !== 1'b1) begin
        errors++;
        $display("FAIL busy n=%0d cycle=%0d got=%b required=1", n, lat, bz);
      end
      if (dn === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    checks++;
    if (!seen || lat != n + 1) begin
      errors++;
      $display("FAIL latency n=%0d seen=%b got=%0d required=%0d", n, seen, lat, n + 1);
    end
    checks++;
    if (r !== er || z !== ez || c !== ec || s !== es) begin
      errors++;
      $display("FAIL result n=%0d op=%b a=%h b=%h cin=%b got R=%h z=%b c=%b s=%b required R=%h z=%b c=%b s=%b",
               n, op, a, b, cin, r, z, c, s, er, ez, ec, es);
    end
    prev_r[n] = er;
  endtask

  task automatic run_model(input int n, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic cin);
    logic [7:0] er;
    logic ez, ec, es;
    model(n, op, a, b, cin, er, ez, ec, es);
    run_op(n, op, a, b, cin, er, ez, ec, es);
  endtask

  task automatic test_reset();
    reset = 1'b1; start1 = 1'b1; start2 = 1'b1;
    op_s = OP_ADD; a_s = 8'h55; b_s = 8'h11; c_in_s = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || r2 !== 8'h00 || zero2 !== 1'b0 ||
        carry2 !== 1'b0 || sign2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_n2 got busy=%b done=%b R=%h z=%b c=%b s=%b required all 0",
               busy2, done2, r2, zero2, carry2, sign2);
    end
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || r1 !== 4'h0 || zero1 !== 1'b0 ||
        carry1 !== 1'b0 || sign1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_n1 got busy=%b done=%b R=%h z=%b c=%b s=%b required all 0",
               busy1, done1, r1, zero1, carry1, sign1);
    end
    reset = 1'b0; start1 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL start_during_reset busy2=%b busy1=%b required 0 0", busy2, busy1);
    end
    prev_r[1] = 8'h00;
    prev_r[2] = 8'h00;
  endtask

  task automatic test_directed();
    run_op(2, OP_ADD, 8'h3A, 8'h2C, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0);
    run_op(2, OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op(2, OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op(2, OP_SUB, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0);
    run_op(1, OP_ADD, 8'h09, 8'h07, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_start();
    int base;
    base = dc2;
    @(negedge clk);
    op_s = OP_ADD; a_s = 8'h12; b_s = 8'h34; c_in_s = 1'b1; start2 = 1'b1;
    @(negedge clk);
    a_s = 8'hF0; b_s = 8'hF0;
    repeat (2) @(negedge clk);
    checks++;
    if (done2 !== 1'b1 || r2 !== 8'h47) begin
      errors++;
      $display("FAIL ignore_start_result got done=%b R=%h required done=1 R=47", done2, r2);
    end
    @(negedge clk);
    start2 = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (dc2 - base != 1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_count got dones=%0d busy=%b required 1 0", dc2 - base, busy2);
    end
    prev_r[2] = 8'h47;
  endtask

  task automatic test_abort();
    int base;
    @(negedge clk);
    op_s = OP_ADD; a_s = 8'h21; b_s = 8'h43; c_in_s = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; reset = 1'b1;
    base = dc2;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || r2 !== 8'h00 || state2 !== S_IDLE) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b R=%h state=%0d required 0 0 00 IDLE",
               busy2, done2, r2, state2);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (dc2 != base) begin
      errors++;
      $display("FAIL abort_no_done got dones=%0d required 0", dc2 - base);
    end
    prev_r[1] = 8'h00;
    prev_r[2] = 8'h00;
    run_op(2, OP_ADD, 8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_logic(input int n);
    for (int i = 0; i < 8; i++) begin
      run_model(n, {1'b1, 2'(i % 4)}, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    run_model(n, OP_AND, 8'hA5, 8'h5A, 1'b1);
  endtask

  task automatic test_back_to_back(input int n);
    for (int i = 0; i < 10; i++) begin
      run_model(n, 3'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_abort();
    test_logic(2);
    test_logic(1);
    test_back_to_back(2);
    test_back_to_back(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
